// File: rtl/imem_port_arbiter.sv
// Two-port arbiter for the I-cache refill port: the cache controller (port 0) and the
// next-line prefetcher (port 1) share one line-wide imem read, one transaction at a time.
module imem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT     = 64,
  parameter int PRIO0_FIXED = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] line_out,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_done_in,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
  logic [DATA_W-1:0]   line_q, line_d;
  logic                mreq_q, mreq_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                busy_q, busy_d;
  logic                pick1;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    line_d  = line_q;
    mreq_d  = mreq_q;
    maddr_d = maddr_q;
    pick1   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Port 1 wins when alone, or on a tie in round-robin mode when it is preferred.
          pick1   = req1 && (!req0 || ((PRIO0_FIXED == 0) && rr_q));
          owner_d = pick1;
          maddr_d = pick1 ? addr1 : addr0;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mreq_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done_in) begin
          line_d  = mem_data_in;
          done0_d = !owner_q;
          done1_d = owner_q;
          mreq_d  = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err0_d  = !owner_q;
          err1_d  = owner_q;
          mreq_d  = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rr_d    = !owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      line_q  <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      line_q  <= line_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err0       = err0_q;
  assign err1       = err1_q;
  assign line_out   = line_q;
  assign mem_req_o  = mreq_q;
  assign mem_addr_o = maddr_q;
  assign busy       = busy_q;

endmodule
